// File: rtl/multi_decade_down_counter_pkg.sv
// Shared BCD constants and helpers for the cascaded BCD down-counter.
package multi_decade_down_counter_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

    // Force a raw nibble into the legal BCD range by saturating at 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/multi_decade_down_counter_digit.sv
// One BCD decade of the down-counter: load, or step down with 0 -> 9 roll.
module bcd_down_digit
    import multi_decade_down_counter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BCD_W-1:0] load_d,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             is_zero,
    output logic             borrow_out
);

    // Digit register: load beats decrement, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= load_d;
        end else if (en) begin
            q <= (q == BCD_MIN) ? BCD_MAX : (q - BCD_W'(1));
        end
    end

    // A borrow leaves this decade only when it is asked to step from 0.
    always_comb begin
        is_zero    = (q == BCD_MIN);
        borrow_out = en & is_zero;
    end

endmodule

// File: rtl/multi_decade_down_counter.sv
// Cascaded BCD down-counter with parallel preset, zero flag and borrow out.
// Build option: define AUTO_RELOAD_EN to reload the last preset value on
// underflow instead of wrapping to all nines.
module multi_decade_down_counter
    import multi_decade_down_counter_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    zero,
    output logic                    borrow
);

    localparam int unsigned CNT_W = BCD_W * DIGITS;

    logic [CNT_W-1:0]  load_clamped;
    logic [CNT_W-1:0]  digit_load_val;
    logic              digit_load;
    logic [DIGITS:0]   chain;
    logic [DIGITS-1:0] dig_zero;

    // Saturate every preset nibble so the count never holds a non-BCD digit.
    always_comb begin
        load_clamped = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            load_clamped[k*BCD_W +: BCD_W] = bcd_clamp(load_val[k*BCD_W +: BCD_W]);
        end
    end

`ifdef AUTO_RELOAD_EN
    logic [CNT_W-1:0] reload_q;

    // Remember the last clamped preset as the underflow reload value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_clamped;
        end
    end

    // Underflow becomes a reload; an explicit preset still takes precedence.
    always_comb begin
        digit_load     = load | borrow;
        digit_load_val = load ? load_clamped : reload_q;
    end
`else
    // Underflow is left to the digits, which roll 0 -> 9 on their own.
    always_comb begin
        digit_load     = load;
        digit_load_val = load_clamped;
    end
`endif

    assign chain[0] = enable;

    genvar g;
    generate
        for (g = 0; g < int'(DIGITS); g++) begin : g_digit
            bcd_down_digit u_digit (
                .clk        (clk),
                .reset_n    (reset_n),
                .load       (digit_load),
                .load_d     (digit_load_val[g*BCD_W +: BCD_W]),
                .en         (chain[g]),
                .q          (count[g*BCD_W +: BCD_W]),
                .is_zero    (dig_zero[g]),
                .borrow_out (chain[g+1])
            );
        end
    endgenerate

    // Flags come straight from the registered digits and the enable chain.
    always_comb begin
        zero   = &dig_zero;
        borrow = chain[DIGITS];
    end

endmodule

// File: tb/tb_multi_decade_down_counter.sv
// Scoreboard bench for the cascaded BCD down-counter (both AUTO_RELOAD_EN builds).
module tb_multi_decade_down_counter;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned CNT_W  = 4 * DIGITS;
    localparam int unsigned MOD    = 10 ** DIGITS;

    typedef struct {
        int unsigned cnt;
        bit          z;
        bit          b;
        string       tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count;
    logic             zero;
    logic             borrow;

    exp_t        sb_q[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference state kept as plain decimal integers.
    int unsigned m_count  = 0;
    int unsigned m_reload = 0;

    multi_decade_down_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .zero     (zero),
        .borrow   (borrow)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] to_bcd(input int unsigned v);
        logic [CNT_W-1:0] r;
        int unsigned      t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal value of a preset with every over-range digit saturated at 9.
    function automatic int unsigned clamp_val(input logic [CNT_W-1:0] raw);
        int unsigned v;
        int unsigned d;
        v = 0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            d = int'(raw[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    // Drive one cycle's inputs, record what the outputs must show, advance the model.
    task automatic cyc(input bit en, input bit ld, input logic [CNT_W-1:0] val, input string tag);
        exp_t e;
        @(negedge clk);
        enable   = en;
        load     = ld;
        load_val = val;
        e.cnt = m_count;
        e.z   = (m_count == 0);
        e.b   = en && (m_count == 0);
        e.tag = tag;
        sb_q.push_back(e);
        if (ld) begin
            m_count  = clamp_val(val);
            m_reload = m_count;
        end else if (en) begin
            if (m_count == 0) begin
`ifdef AUTO_RELOAD_EN
                m_count = m_reload;
`else
                m_count = MOD - 1;
`endif
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    // Assert reset away from any clock edge; the clear must be visible before the next edge.
    task automatic async_reset(input string tag);
        exp_t e;
        @(negedge clk);
        reset_n  = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        m_count  = 0;
        m_reload = 0;
        e.cnt = 0;
        e.z   = 1'b1;
        e.b   = 1'b0;
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: the counter presents its outputs every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (count !== to_bcd(e.cnt) || zero !== e.z || borrow !== e.b) begin
                    n_fail++;
                    $display("FAIL %s: got count=%h zero=%b borrow=%b, expected count=%h zero=%b borrow=%b",
                             e.tag, count, zero, borrow, to_bcd(e.cnt), e.z, e.b);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        load_val = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        cyc(0, 0, '0, "reset_state");

        // Mid-count asynchronous reset, then hold.
        cyc(0, 1, 12'h473, "load_473");
        cyc(1, 0, '0, "dec_to_472");
        cyc(0, 0, '0, "at_472");
        async_reset("async_clear");
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, "hold_after_reset");

        // Decade borrow.
        cyc(0, 1, 12'h100, "load_100");
        for (int i = 0; i < 3; i++) cyc(1, 0, '0, "dec_from_100");
        cyc(0, 1, 12'h010, "load_010");
        cyc(1, 0, '0, "dec_from_010");
        cyc(0, 0, '0, "at_009");

        // Clamp and load priority.
        cyc(0, 1, 12'hA5F, "clamp_A5F");
        cyc(1, 1, 12'h999, "load_beats_enable");
        cyc(0, 0, '0, "at_999");

        // Underflow: wrap or reload depending on build.
        cyc(0, 1, 12'h002, "load_002");
        for (int i = 0; i < 6; i++) cyc(1, 0, '0, "underflow_run");
        cyc(0, 1, 12'h003, "load_003");
        for (int i = 0; i < 10; i++) cyc(1, 0, '0, "periodic_run");
        cyc(0, 1, 12'h000, "load_000");
        for (int i = 0; i < 4; i++) cyc(1, 0, '0, "zero_reload_run");

        // Load and enable together while at zero: load wins, borrow still fires.
        cyc(0, 1, 12'h000, "load_000_again");
        cyc(1, 1, 12'h321, "load_enable_at_zero");
        cyc(0, 0, '0, "at_321");

        // Full sweep from 999.
        cyc(0, 1, 12'h999, "load_999_sweep");
        for (int i = 0; i < 1001; i++) cyc(1, 0, '0, "sweep");

        // Random mix, including occasional resets and non-BCD presets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand_reset");
            end else begin
                cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 29) == 0),
                    CNT_W'($urandom), "random");
            end
        end

        cyc(0, 0, '0, "final");
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
